// File: rtl/vga_pkg.sv
// Shared types and helpers for the VGA scan-out block: pixel colour struct,
// frame-buffer word unpacking and timing arithmetic.
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Frame-buffer words are 0x??RRGGBB; the top byte is padding.
    function automatic rgb_t rgb_from_word(input logic [31:0] w);
        rgb_t       c;
        logic [7:0] unused_pad;
        unused_pad = w[31:24];
        c.r = w[23:16];
        c.g = w[15:8];
        c.b = w[7:0];
        return c;
    endfunction

    function automatic int line_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    function automatic logic sync_level(input logic in_window, input logic pol);
        return in_window ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Fixed-depth shift register used to align timing flags with frame-buffer
// read data; resets every stage to a caller-chosen idle value.
module vga_delay_line #(
    parameter int               WIDTH   = 3,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] stage_p [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < DEPTH; i++) stage_p[i] <= RST_VAL;
        end else begin
            stage_p[0] <= i_d;
            for (int i = 1; i < DEPTH; i++) stage_p[i] <= stage_p[i-1];
        end
    end

    assign o_q = stage_p[DEPTH-1];

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out: timing counters, replicated frame-buffer addressing with a
// per-frame base, and a latency-matched registered DAC interface.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int   H_ACTIVE   = 640,
    parameter int   H_FP       = 16,
    parameter int   H_SYNC     = 96,
    parameter int   H_BP       = 48,
    parameter int   V_ACTIVE   = 480,
    parameter int   V_FP       = 10,
    parameter int   V_SYNC     = 2,
    parameter int   V_BP       = 33,
    parameter logic HS_POL     = 1'b0,
    parameter logic VS_POL     = 1'b0,
    parameter int   SCALE_LOG2 = 1,
    parameter int   ADDR_W     = 18,
    parameter int   RD_LATENCY = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_enable,
    input  logic [ADDR_W-1:0] i_fb_base,
    output logic [ADDR_W-1:0] A_VGA,
    input  logic [31:0]       RD_VGA,
    output logic              o_hs,
    output logic              o_vs,
    output logic              o_blanking,
    output logic              o_sync,
    output logic              o_clk,
    output logic [7:0]        o_r,
    output logic [7:0]        o_g,
    output logic [7:0]        o_b,
    output logic              o_vblank
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int SCALE   = 1 << SCALE_LOG2;
    localparam int SRC_W   = H_ACTIVE >> SCALE_LOG2;

    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_SS   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] H_SE   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] V_PRE  = VW'(V_ACTIVE - 1);
    localparam logic [VW-1:0] V_SS   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] V_SE   = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [VW-1:0] V_MASK = VW'(SCALE - 1);
    localparam logic [ADDR_W-1:0] SRC_STEP = ADDR_W'(SRC_W);

    logic [HW-1:0]     h_cnt;
    logic [VW-1:0]     v_cnt;
    logic [VW-1:0]     v_inc;
    logic              h_wrap;
    logic              frame_wrap;
    logic              line_step;
    logic [ADDR_W-1:0] fb_base_q;
    logic [ADDR_W-1:0] line_off;
    logic              vld_p0, hs_p0, vs_p0;
    logic              vld_p1, hs_p1, vs_p1;
    rgb_t              rgb_p2;

    assign h_wrap     = (h_cnt == H_LAST);
    assign frame_wrap = h_wrap && (v_cnt == V_LAST);
    assign v_inc      = v_cnt + 1'b1;
    // Source line advances only after the last replicated copy of it.
    assign line_step  = ((v_inc & V_MASK) == '0) && (v_cnt < V_ACT);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_wrap) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? '0 : v_inc;
        end else begin
            h_cnt <= h_cnt + 1'b1;
        end
    end

    // line_base is fb_base_q + line_off; the base is only latched at frame wrap.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            fb_base_q <= '0;
            line_off  <= '0;
        end else if (frame_wrap) begin
            fb_base_q <= i_fb_base;
            line_off  <= '0;
        end else if (h_wrap && line_step) begin
            line_off <= line_off + SRC_STEP;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) o_vblank <= 1'b0;
        else        o_vblank <= h_wrap && (v_cnt == V_PRE);
    end

    // ---- stage p0: raw timing from counters ----
    always_comb begin
        vld_p0 = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        hs_p0  = sync_level((h_cnt >= H_SS) && (h_cnt < H_SE), HS_POL);
        vs_p0  = sync_level((v_cnt >= V_SS) && (v_cnt < V_SE), VS_POL);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst)      A_VGA <= '0;
        else if (vld_p0) A_VGA <= fb_base_q + line_off + ADDR_W'(h_cnt >> SCALE_LOG2);
    end

    // ---- stage p1: flags delayed to line up with RD_VGA ----
    vga_delay_line #(
        .WIDTH   (3),
        .DEPTH   (RD_LATENCY + 1),
        .RST_VAL ({1'b0, ~HS_POL, ~VS_POL})
    ) u_align (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_d   ({vld_p0, hs_p0, vs_p0}),
        .o_q   ({vld_p1, hs_p1, vs_p1})
    );

    // ---- stage p2: registered DAC pins ----
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            rgb_p2     <= '0;
            o_blanking <= 1'b0;
            o_hs       <= ~HS_POL;
            o_vs       <= ~VS_POL;
        end else begin
            rgb_p2     <= (vld_p1 && i_enable) ? rgb_from_word(RD_VGA) : '0;
            o_blanking <= vld_p1;
            o_hs       <= hs_p1;
            o_vs       <= vs_p1;
        end
    end

    assign o_r    = rgb_p2.r;
    assign o_g    = rgb_p2.g;
    assign o_b    = rgb_p2.b;
    assign o_sync = 1'b0;
    assign o_clk  = i_clk;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout on a reduced 24x12 timing with 2x
// replication and a 3-cycle frame-buffer model.
module tb_vga_scanout;

    localparam int HT    = 24;
    localparam int VT    = 12;
    localparam int FRAME = HT * VT;
    localparam int LAT   = 5;     // RD_LATENCY + 2
    localparam int VBL_K = 8 * HT;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [17:0] fb_base;
    logic [17:0] a_vga;
    logic [31:0] rd_vga;
    logic        hs, vs, blank, sync_n, dac_clk, vblank;
    logic [7:0]  r, g, b;

    logic [17:0]  ram_pipe [3];
    logic [23:0]  exp_q [$];
    int           checks   = 0;
    int           failures = 0;
    int           bases [3];

    always #5 clk = ~clk;

    vga_scanout #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .SCALE_LOG2(1),
        .ADDR_W(18), .RD_LATENCY(3)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_enable(en), .i_fb_base(fb_base),
        .A_VGA(a_vga), .RD_VGA(rd_vga), .o_hs(hs), .o_vs(vs),
        .o_blanking(blank), .o_sync(sync_n), .o_clk(dac_clk),
        .o_r(r), .o_g(g), .o_b(b), .o_vblank(vblank)
    );

    function automatic logic [31:0] ram_word(input logic [17:0] a);
        return {8'hC3, a[7:0] ^ 8'h5A, a[15:8] ^ {6'b0, a[17:16]}, a[7:0]};
    endfunction

    // Frame-buffer RAM model: data for an address appears three clocks later.
    always @(posedge clk) begin
        ram_pipe[0] <= a_vga;
        ram_pipe[1] <= ram_pipe[0];
        ram_pipe[2] <= ram_pipe[1];
    end
    assign rd_vga = ram_word(ram_pipe[2]);

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0d: actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    function automatic logic [17:0] pix_addr(input int base, input int y, input int x);
        return 18'(base + (y / 2) * 8 + (x / 2));
    endfunction

    task automatic push_frame(input int base, input int dark_line);
        logic [31:0] w;
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 16; x++) begin
                w = ram_word(pix_addr(base, y, x));
                exp_q.push_back((y == dark_line) ? 24'h0 : w[23:0]);
            end
    endtask

    // Timing, address and vblank checks for the cycle sampled after edge k.
    task automatic check_cycle(input int k);
        int p, c, h, v;
        logic eb, ehs, evs;
        p = k - LAT;
        if (p < 0) begin
            eb = 1'b0; ehs = 1'b1; evs = 1'b1;
        end else begin
            h = p % HT; v = (p / HT) % VT;
            eb  = (h < 16) && (v < 8);
            ehs = !((h >= 18) && (h < 21));
            evs = !((v >= 9) && (v < 11));
        end
        chk("blanking", k, blank, eb);
        chk("hs", k, hs, ehs);
        chk("vs", k, vs, evs);
        if (!eb) chk("rgb_blank", k, {r, g, b}, 0);
        chk("vblank", k, vblank, (k % FRAME) == VBL_K);
        c = k - 1;
        h = c % HT; v = (c / HT) % VT;
        if (h < 16 && v < 8 && (c / FRAME) < 3)
            chk("addr", k, a_vga, pix_addr(bases[c / FRAME], v, h));
    endtask

    task automatic check_reset_pins(input string name);
        chk({name, "_hs"}, 0, hs, 1);
        chk({name, "_vs"}, 0, vs, 1);
        chk({name, "_blanking"}, 0, blank, 0);
        chk({name, "_rgb"}, 0, {r, g, b}, 0);
        chk({name, "_vblank"}, 0, vblank, 0);
        chk({name, "_addr"}, 0, a_vga, 0);
        chk({name, "_sync_n"}, 0, sync_n, 0);
    endtask

    // Monitor: every visible pixel on the pins must match the next expectation.
    initial begin
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && blank === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("pixel_underflow", 0, 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pixel", 0, {r, g, b}, e);
                end
            end
        end
    end

    initial begin
        int p;
        rst_n   = 1'b0;
        en      = 1'b1;
        fb_base = 18'd0;
        bases   = '{0, 32, 262134};
        repeat (3) @(negedge clk);
        check_reset_pins("reset");

        push_frame(0, -1);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= 711; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(k);
            p = k - LAT;
            if (k == 100) begin
                fb_base = 18'd32;
                push_frame(32, 3);
            end
            if (k == FRAME + 100) begin
                fb_base = 18'd262134;
                push_frame(262134, -1);
            end
            if (p == FRAME + 2 * HT + 20) en = 1'b0;
            if (p == FRAME + 3 * HT + 20) en = 1'b1;
        end

        // Abort in the middle of a visible line of the third frame.
        #2 rst_n = 1'b0;
        #1 check_reset_pins("async_reset");
        exp_q.delete();
        repeat (2) @(negedge clk);
        bases = '{0, 0, 0};
        push_frame(0, -1);
        #1 rst_n = 1'b1;
        for (int k = 1; k <= FRAME; k++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(k);
        end
        chk("queue_drained", 0, exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
